// File: rtl/crono_display.sv
// crono_display: converts the chronometer count (cc, SS, MM, HH) to BCD and scans it onto an 8-digit active-low 7-segment display.
// Latency: 15 cycles from input sample (LOAD) to the displayed digits; segment/anode/dp outputs follow 1 cycle later.
// Backpressure: none; a conversion request arriving while a conversion is running is dropped, never queued.
module crono_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] seg,
  input  logic [5:0]  minu,
  input  logic [4:0]  h,
  input  logic        blank,
  output logic [6:0]  seg7_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        busy
);

  localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          first_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic          tick;
  logic [3:0]    iter_q;

  // Shift sources (MSB enters the accumulators) and BCD accumulators.
  logic [12:0]   src_s_q, src_m_q, src_h_q;
  logic [15:0]   acc_s_q, acc_s_d;
  logic [7:0]    acc_m_q, acc_m_d;
  logic [7:0]    acc_h_q, acc_h_d;
  logic [12:0]   seg_sat;
  logic [5:0]    minu_sat;
  logic [4:0]    h_sat;

  // Displayed digits, nibble i = digit i (digit 0 = rightmost).
  logic [31:0]   disp_q;
  logic [3:0]    cur_dig;

  logic [6:0]    seg7_n_q, seg7_n_d;
  logic          dp_n_q, dp_n_d;
  logic [7:0]    an_n_q, an_n_d;

  // Add 3 to each BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [7:0] adj8(input logic [7:0] v);
    logic [3:0] lo, hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    return {hi, lo};
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-decimal codes are dark.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick = (cnt_q == CNT_MAX);

  // Digit-slot timer and the current digit index; both keep running while blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // State register; first_q requests one conversion right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
    end
  end

  // Next state: start only from IDLE, so requests during a conversion are lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (first_q || (tick && idx_q == 3'd7)) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SHIFT;
      ST_SHIFT:  if (iter_q == 4'd12) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Input saturation and one double-dabble step for all three engines.
  always_comb begin
    seg_sat  = (seg  > 13'd5999) ? 13'd5999 : seg;
    minu_sat = (minu > 6'd59)    ? 6'd59    : minu;
    h_sat    = (h    > 5'd23)    ? 5'd23    : h;
    acc_s_d  = ({adj8(acc_s_q[15:8]), adj8(acc_s_q[7:0])} << 1) | {15'd0, src_s_q[12]};
    acc_m_d  = (adj8(acc_m_q) << 1) | {7'd0, src_m_q[12]};
    acc_h_d  = (adj8(acc_h_q) << 1) | {7'd0, src_h_q[12]};
  end

  // Conversion datapath; the displayed digits only change in COMMIT, all at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_s_q <= '0;
      src_m_q <= '0;
      src_h_q <= '0;
      acc_s_q <= '0;
      acc_m_q <= '0;
      acc_h_q <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          src_s_q <= seg_sat;
          src_m_q <= {7'd0, minu_sat};
          src_h_q <= {8'd0, h_sat};
          acc_s_q <= '0;
          acc_m_q <= '0;
          acc_h_q <= '0;
          iter_q  <= '0;
        end
        ST_SHIFT: begin
          acc_s_q <= acc_s_d;
          acc_m_q <= acc_m_d;
          acc_h_q <= acc_h_d;
          src_s_q <= src_s_q << 1;
          src_m_q <= src_m_q << 1;
          src_h_q <= src_h_q << 1;
          iter_q  <= iter_q + 4'd1;
        end
        ST_COMMIT: disp_q <= {acc_h_q, acc_m_q, acc_s_q};
        default: ;
      endcase
    end
  end

  // Decode of the current slot: segments, anode and separator dots (after cc, SS, MM).
  always_comb begin
    cur_dig  = disp_q[{idx_q, 2'b00} +: 4];
    seg7_n_d = dec7(cur_dig);
    if (LZ_BLANK && idx_q == 3'd7 && cur_dig == 4'd0) seg7_n_d = 7'h7F;
    an_n_d   = blank ? 8'hFF : ~(8'd1 << idx_q);
    dp_n_d   = blank | ~(idx_q == 3'd2 || idx_q == 3'd4 || idx_q == 3'd6);
  end

  // Registered display drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg7_n_q <= 7'h7F;
      dp_n_q   <= 1'b1;
      an_n_q   <= 8'hFF;
    end else begin
      seg7_n_q <= seg7_n_d;
      dp_n_q   <= dp_n_d;
      an_n_q   <= an_n_d;
    end
  end

  assign seg7_n = seg7_n_q;
  assign dp_n   = dp_n_q;
  assign an_n   = an_n_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crono_display.sv
// tb_crono_display: randomized + directed stimulus, scoreboard of expected digit frames checked per scan frame.
// Two instances (no leading-zero blanking / with it) share all inputs.
// Expected frames are pushed when a conversion starts and popped when it finishes.
module tb_crono_display;
  localparam int SD = 16;
  localparam int FRAME = 8 * SD;

  logic        clk, rst_n, blank;
  logic [12:0] seg_i;
  logic [5:0]  minu_i;
  logic [4:0]  h_i;
  logic [6:0]  seg7_n_a, seg7_n_b;
  logic        dp_n_a, dp_n_b, busy_a, busy_b;
  logic [7:0]  an_n_a, an_n_b;

  crono_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .seg(seg_i), .minu(minu_i), .h(h_i), .blank(blank),
    .seg7_n(seg7_n_a), .dp_n(dp_n_a), .an_n(an_n_a), .busy(busy_a));

  crono_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .seg(seg_i), .minu(minu_i), .h(h_i), .blank(blank),
    .seg7_n(seg7_n_b), .dp_n(dp_n_b), .an_n(an_n_b), .busy(busy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int frames_checked = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: the eight digits (digit 7 in the top nibble) from plain decimal arithmetic.
  function automatic logic [31:0] model(input int s, input int m, input int hh);
    if (s > 5999) s = 5999;
    if (m > 59) m = 59;
    if (hh > 23) hh = 23;
    return {4'(hh / 10), 4'(hh % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Expectation producer: the inputs present in the first busy cycle are the ones converted.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (busy_a && !prev) exp_q.push_back(model(int'(seg_i), int'(minu_i), int'(h_i)));
        prev = busy_a;
      end
    end
  end

  // Monitor state: one full scan frame is captured after each completed conversion.
  logic [31:0] cur_exp, pend_exp;
  bit          cap_active, cap_bad, start_pending, prev_busy, blank_prev, prev_an_v;
  int          cap_cnt, bad_an, busy_cnt, busy_cnt_b;
  bit          seen[8];
  logic [6:0]  got_a[8], got_b[8];
  logic        got_dp[8];
  int          slot_cnt[8];
  logic [7:0]  prev_an;

  task automatic cap_start();
    cur_exp = pend_exp;
    cap_active = 1'b1; cap_bad = 1'b0; cap_cnt = 0; bad_an = 0; prev_an_v = 1'b0;
    for (int i = 0; i < 8; i++) begin seen[i] = 1'b0; slot_cnt[i] = 0; end
  endtask

  task automatic cap_sample();
    int k;
    if (blank || blank_prev) cap_bad = 1'b1;
    if ($countones(~an_n_a) == 1) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (!an_n_a[i]) k = i;
      slot_cnt[k]++;
      if (!seen[k]) begin
        seen[k] = 1'b1; got_a[k] = seg7_n_a; got_b[k] = seg7_n_b; got_dp[k] = dp_n_a;
      end
      if (prev_an_v && an_n_a != prev_an && !cap_bad)
        chk("an_step", an_n_a, {prev_an[6:0], prev_an[7]});
      prev_an = an_n_a; prev_an_v = 1'b1;
    end else bad_an++;
    cap_cnt++;
  endtask

  task automatic cap_finish();
    logic [3:0] d;
    logic [6:0] ea, eb;
    if (!cap_bad) begin
      chk("an_onehot_violations", bad_an, 0);
      for (int k = 0; k < 8; k++) begin
        d  = cur_exp[4*k +: 4];
        ea = seg_pat(d);
        eb = (k == 7 && d == 4'd0) ? 7'h7F : ea;
        chk($sformatf("slot%0d_seg7", k), got_a[k], ea);
        chk($sformatf("slot%0d_seg7_lz", k), got_b[k], eb);
        chk($sformatf("slot%0d_dp", k), got_dp[k], (k == 2 || k == 4 || k == 6) ? 0 : 1);
        chk($sformatf("slot%0d_hold", k), slot_cnt[k], SD);
      end
      frames_checked++;
    end
    cap_active = 1'b0;
  endtask

  // Monitor: pops an expectation when busy falls, then checks the following scan frame.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cap_active = 1'b0; start_pending = 1'b0; prev_busy = 1'b0;
        busy_cnt = 0; busy_cnt_b = 0; blank_prev = blank;
      end else begin
        if (cap_active) begin
          cap_sample();
          if (cap_cnt == FRAME) cap_finish();
        end
        if (start_pending && !cap_active) begin
          cap_start();
          start_pending = 1'b0;
          cap_sample();
        end
        if (busy_a) busy_cnt++;
        if (busy_b) busy_cnt_b++;
        if (prev_busy && !busy_a) begin
          chk("busy_len", busy_cnt, 15);
          chk("busy_len_lz", busy_cnt_b, 15);
          busy_cnt = 0; busy_cnt_b = 0;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_underflow actual=empty required=entry t=%0t", $time);
          end else begin
            pend_exp = exp_q.pop_front();
            start_pending = 1'b1;
          end
        end
        prev_busy = busy_a;
        blank_prev = blank;
      end
    end
  end

  task automatic wait_busy(input logic lvl, input int lim, input string nm);
    int n;
    n = 0;
    while (busy_a !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy_a, lvl);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_seg7"}, seg7_n_a, 7'h7F);
    chk({pfx, "_dp"}, dp_n_a, 1);
    chk({pfx, "_an"}, an_n_a, 8'hFF);
    chk({pfx, "_busy"}, busy_a, 0);
    chk({pfx, "_an_lz"}, an_n_b, 8'hFF);
    chk({pfx, "_dp_lz"}, dp_n_b, 1);
  endtask

  // Driver: inputs change 2 time units after a rising edge.
  initial begin
    rst_n = 1'b1; blank = 1'b0;
    seg_i = 13'd1234; minu_i = 6'd5; h_i = 5'd17;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3 * FRAME) @(posedge clk);

    // Saturation of out-of-range inputs.
    #2 seg_i = 13'd6000; minu_i = 6'd63; h_i = 5'd31;
    repeat (3 * FRAME) @(posedge clk);

    // Input change while shifting must not disturb the running conversion.
    #2 seg_i = 13'd100; minu_i = 6'd0; h_i = 5'd3;
    wait_busy(1'b0, 4 * FRAME, "wait_idle_mid");
    wait_busy(1'b1, 4 * FRAME, "wait_start_mid");
    repeat (5) @(posedge clk);
    #2 seg_i = 13'd200;
    repeat (3 * FRAME) @(posedge clk);

    // Blanking: masks outputs one cycle later, scanning continues.
    #2 blank = 1'b1;
    @(negedge clk);
    chk("blank_not_yet", $countones(~an_n_a), 1);
    @(negedge clk);
    chk("blank_an", an_n_a, 8'hFF);
    chk("blank_dp", dp_n_a, 1);
    chk("blank_an_lz", an_n_b, 8'hFF);
    repeat (20) @(posedge clk);
    #2 blank = 1'b0;
    @(negedge clk);
    chk("unblank_delay", an_n_a, 8'hFF);
    @(negedge clk);
    chk("unblank_onehot", $countones(~an_n_a), 1);
    repeat (2 * FRAME) @(posedge clk);

    // Reset in the middle of SHIFT.
    wait_busy(1'b0, 4 * FRAME, "wait_idle_rst");
    wait_busy(1'b1, 4 * FRAME, "wait_start_rst");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 chk_reset_outputs("midreset");
    #9 rst_n = 1'b1;
    wait_busy(1'b1, 20, "restart_after_reset");
    repeat (3 * FRAME) @(posedge clk);

    // Randomized inputs, including out-of-range and boundary values.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(1, 250)) @(posedge clk);
      #2;
      seg_i  = 13'($urandom_range(0, 8191));
      minu_i = 6'($urandom_range(0, 63));
      h_i    = 5'($urandom_range(0, 31));
      if (r % 5 == 0) seg_i = (r % 10 == 0) ? 13'd5999 : 13'd6000;
      if (r % 7 == 0) h_i = 5'd0;
    end
    repeat (3 * FRAME) @(posedge clk);

    chk("frames_checked_min", (frames_checked >= 15) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crono_display.md
Name: crono_display

Overview:
- Downstream display stage for the chronometer.
- Consumes the centisecond count (seg, 0..5999), minutes (minu, 0..59) and hours (h, 0..23).
- Converts each value to BCD with a sequential shift-add-3 engine.
- Drives an 8-digit, multiplexed, active-low 7-segment display as HH.MM.SS.cc. Digit 0 is the rightmost digit (centiseconds ones).

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz digit rate at 50 MHz). Must be >= 16.
- LZ_BLANK, 0: 1 = blank the hours-tens digit when it is 0.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg  input  13  centiseconds within the minute, 0..5999.
- minu  input  6  minutes, 0..59.
- h  input  5  hours, 0..23.
- blank  input  1  1 = all digits off.
- seg7_n  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- dp_n  output  1  decimal point, active-low.
- an_n  output  8  digit enables, active-low, one-hot-low; bit i = digit i.
- busy  output  1  high while a BCD conversion is in progress.

Behaviour:
- Reset (async, while rst_n=0):
  - seg7_n=7'h7F, dp_n=1, an_n=8'hFF, busy=0.
  - Digit register idx=0, scan counter=0, FSM=IDLE, all eight displayed BCD digits=0.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps. The tick is the cycle where the counter equals SCAN_DIV-1.
  - On tick, idx <= idx+1, wrapping 7->0.
- Output registers:
  - an_n, seg7_n and dp_n are registered decodes of idx, the displayed digits and blank.
  - They change exactly 1 cycle after idx, a digit register, or blank changes.
  - an_n = ~(1<<idx) when blank=0; 8'hFF when blank=1.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any non-decimal code = 1111111.
- Decimal point: dp_n=0 when idx is 2, 4 or 6 (separators after cc, SS, MM); otherwise dp_n=1. Forced to 1 when blank=1.
- Leading-zero blanking: with LZ_BLANK=1 and hours-tens digit (idx 7) = 0, seg7_n=7'h7F in that slot. an_n still asserts.
- Digit map: idx0/1 = cc ones/tens; idx2/3 = SS ones/tens; idx4/5 = MM ones/tens; idx6/7 = HH ones/tens.
  - The seg value converts directly as 4 BCD digits, e.g. 5999 -> "59.99".
- Conversion FSM (IDLE -> LOAD -> SHIFT -> COMMIT -> IDLE):
  - Start condition: first cycle after reset release, or any tick with idx==7 (frame wrap) while in IDLE.
  - A start request arriving while busy is dropped; no queuing.
  - LOAD (1 cycle): sample the inputs with saturation into three zero-extended 13-bit shift sources. Saturation: seg>5999 -> 5999, minu>59 -> 59, h>23 -> 23. Clear the BCD accumulators. busy=1.
  - SHIFT (exactly 13 cycles): each cycle, for each of the three engines in parallel, add 3 to every BCD nibble >= 5, then shift left 1 with the source MSB entering. An iteration counter runs 0..12.
  - COMMIT (1 cycle): copy all 8 digits to the displayed registers atomically; busy=0 next cycle.
  - Latency: sampled input to displayed digits = 15 cycles; seg7_n reflects them 1 cycle later.
  - Inputs changing after LOAD have no effect until the next conversion.
  - No partially converted value is ever displayed.
- Reset asserted mid-conversion aborts it. The display returns to the reset values; no commit occurs.
- blank does not stop scanning or conversion; only the outputs are masked.

Test Plan:
- Reset release with seg=1234, minu=5, h=17 -> busy high for 15 cycles; then the digits idx0..7 read 4,3,2,1,5,0,7,1.
- Scan with SCAN_DIV=16 -> an_n steps FE,FD,FB,...,7F,FE, each held 16 cycles; dp_n=0 only in slots 2, 4, 6.
- Saturation: seg=6000, minu=63, h=31 -> display reads 23.59.59.99.
- Mid-conversion input change: seg changes 100->200 during SHIFT -> "01.00" is shown; "02.00" appears only after the next frame wrap.
- blank=1 -> an_n=FF and dp_n=1 one cycle later; blank=0 resumes at the current idx. LZ_BLANK=1 with h=3 -> slot 7 shows seg7_n=7F.
- rst_n pulsed low during SHIFT -> all outputs return to reset values immediately; a new conversion starts after release.
